// File: rtl/mod_inverse_pkg.sv
// Shared types and constants for the modular-inverse engine.
// The latency bound is also used by the bench as its timeout.
package mod_inverse_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoad    = 2'd1,
        StCompute = 2'd2,
        StDone    = 2'd3
    } state_e;

    // Worst-case edges from start acceptance to done for legal operands.
    function automatic int unsigned latency_bound(input int unsigned width);
        return 4 * width + 3;
    endfunction

endpackage

// File: rtl/mod_halve.sv
// Modular halving for odd m: x/2 mod m. The sum is one bit wider than the
// operands so x+m cannot overflow before the shift.
module mod_halve #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, x} + {1'b0, m};
        y   = x[0] ? WIDTH'(sum >> 1) : (x >> 1);
    end

endmodule

// File: rtl/mod_inverse.sv
// Iterative a^-1 mod m for odd m using binary extended Euclid, one step per clock.
// Invariants: x1*a == u and x2*a == v (mod m); x1, x2 stay in [0, m-1].
module mod_inverse
    import mod_inverse_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH-1:0] inv_out,
    output logic             done,
    output logic             no_inv,
    output logic             busy
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             res_no_q, res_no_d;
    logic [WIDTH-1:0] inv_q, inv_d;
    logic             done_q, done_d;
    logic             no_inv_q, no_inv_d;

    logic [WIDTH-1:0] x1_half, x2_half;
    logic [WIDTH-1:0] x1_sub, x2_sub;
    logic             legal;

    mod_halve #(
        .WIDTH(WIDTH)
    ) u_halve_x1 (
        .x(x1_q),
        .m(m_q),
        .y(x1_half)
    );

    mod_halve #(
        .WIDTH(WIDTH)
    ) u_halve_x2 (
        .x(x2_q),
        .m(m_q),
        .y(x2_half)
    );

    // Modular subtract; the wrapped WIDTH-bit result is exact since it lies in [0, m-1].
    always_comb begin
        x1_sub = (x1_q >= x2_q) ? (x1_q - x2_q) : (x1_q + m_q - x2_q);
        x2_sub = (x2_q >= x1_q) ? (x2_q - x1_q) : (x2_q + m_q - x1_q);
        legal  = m_q[0] && (m_q > WIDTH'(1)) && (a_q != '0) && (a_q < m_q);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        m_d      = m_q;
        u_d      = u_q;
        v_d      = v_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        res_d    = res_q;
        res_no_d = res_no_q;
        inv_d    = inv_q;
        done_d   = done_q;
        no_inv_d = no_inv_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d      = a_in;
                    m_d      = m_in;
                    inv_d    = '0;
                    done_d   = 1'b0;
                    no_inv_d = 1'b0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                res_d = '0;
                if (!legal) begin
                    res_no_d = 1'b1;
                    state_d  = StDone;
                end else begin
                    u_d      = a_q;
                    v_d      = m_q;
                    x1_d     = WIDTH'(1);
                    x2_d     = '0;
                    res_no_d = 1'b0;
                    state_d  = StCompute;
                end
            end
            StCompute: begin
                if (u_q == WIDTH'(1)) begin
                    res_d    = x1_q;
                    res_no_d = 1'b0;
                    state_d  = StDone;
                end else if (v_q == WIDTH'(1)) begin
                    res_d    = x2_q;
                    res_no_d = 1'b0;
                    state_d  = StDone;
                end else if ((u_q == '0) || (v_q == '0)) begin
                    res_d    = '0;
                    res_no_d = 1'b1;
                    state_d  = StDone;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = x1_half;
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = x2_half;
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = x1_sub;
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = x2_sub;
                end
            end
            StDone: begin
                // Outputs publish together, so done, inv_out and no_inv rise on one edge.
                done_d   = 1'b1;
                inv_d    = res_q;
                no_inv_d = res_no_q;
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            m_q      <= '0;
            u_q      <= '0;
            v_q      <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            res_q    <= '0;
            res_no_q <= 1'b0;
            inv_q    <= '0;
            done_q   <= 1'b0;
            no_inv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            m_q      <= m_d;
            u_q      <= u_d;
            v_q      <= v_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            res_q    <= res_d;
            res_no_q <= res_no_d;
            inv_q    <= inv_d;
            done_q   <= done_d;
            no_inv_q <= no_inv_d;
        end
    end

    assign inv_out = inv_q;
    assign done    = done_q;
    assign no_inv  = no_inv_q;
    assign busy    = (state_q == StLoad) || (state_q == StCompute);

endmodule

// File: tb/tb_mod_inverse.sv
// Self-checking bench for mod_inverse: directed cases plus a randomized sweep
// against an ordinary extended-Euclid reference model.
module tb_mod_inverse;
    import mod_inverse_pkg::*;

    localparam int unsigned W     = DefaultWidth;
    localparam int unsigned Bound = latency_bound(W);

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] m_in;
    logic [W-1:0] inv_out;
    logic         done;
    logic         no_inv;
    logic         busy;

    int errors = 0;
    int checks = 0;

    logic         exp_no  = 1'b0;
    logic [W-1:0] exp_inv = '0;

    mod_inverse #(
        .WIDTH(W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a_in(a_in),
        .m_in(m_in),
        .inv_out(inv_out),
        .done(done),
        .no_inv(no_inv),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Reference: classic extended Euclid on signed integers; {no_inv, inverse}.
    function automatic logic [W:0] ref_inv(input logic [W-1:0] a, input logic [W-1:0] m);
        longint r0, r1, t0, t1, q, tmp;
        if (!m[0] || m <= 1 || a == 0 || a >= m) return {1'b1, {W{1'b0}}};
        r0 = {32'd0, m};
        r1 = {32'd0, a};
        t0 = 0;
        t1 = 1;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = r0 - q * r1;
            r0  = r1;
            r1  = tmp;
            tmp = t0 - q * t1;
            t0  = t1;
            t1  = tmp;
        end
        if (r0 != 1) return {1'b1, {W{1'b0}}};
        if (t0 < 0) t0 = t0 + {32'd0, m};
        return {1'b0, t0[W-1:0]};
    endfunction

    // Outputs are meaningful whenever done is high (including held in IDLE).
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            check("inv_out", inv_out, exp_inv);
            check("no_inv", no_inv, exp_no);
            check("busy_low_while_done", busy, 1'b0);
        end
    end

    // Called at posedge+1 with the DUT idle and start low.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] m, input logic e_no,
                       input logic [W-1:0] e_inv, input int hold, input bit pulse);
        int          n;
        bit          seen;
        bit          illegal;
        logic [63:0] prod;
        illegal = !m[0] || (m <= 1) || (a == 0) || (a >= m);
        a_in  = a;
        m_in  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_no  = e_no;
        exp_inv = e_inv;
        if (hold == 0) start = 1'b0;
        seen = 1'b0;
        for (n = 1; n <= int'(Bound) + 2; n++) begin
            if (pulse && n == 3) begin
                start = 1'b1;
                a_in  = 32'd5;
                m_in  = 32'd7;
            end
            if (pulse && n == 4) start = 1'b0;
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL timeout: no done within %0d edges (a=0x%0h m=0x%0h)", Bound + 2, a, m);
        end else if (illegal) begin
            check("illegal_latency_edges", n, 2);
        end else begin
            check("latency_within_bound", (n <= int'(Bound)), 1'b1);
            if (no_inv === 1'b0) begin
                prod = ({32'd0, a} * {32'd0, inv_out}) % {32'd0, m};
                check("a_times_inv_mod_m", prod, 1);
            end
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
                check("held_start_done", done, 1'b1);
                check("held_start_no_retrigger", busy, 1'b0);
            end
            start = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [W-1:0] ra, rm;
        logic [W:0]   r;
        int           sel;

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        m_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_inv_out", inv_out, 0);
        check("reset_done", done, 0);
        check("reset_no_inv", no_inv, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        check("model_3_11", ref_inv(32'd3, 32'd11), {1'b0, 32'd4});
        check("model_7_15", ref_inv(32'd7, 32'd15), {1'b0, 32'd13});
        check("model_2_ffffffff", ref_inv(32'd2, 32'hFFFF_FFFF), {1'b0, 32'h8000_0000});
        check("model_6_9", ref_inv(32'd6, 32'd9), {1'b1, 32'd0});

        run(32'd3, 32'd11, 1'b0, 32'd4, 0, 0);
        run(32'd7, 32'd15, 1'b0, 32'd13, 0, 0);
        run(32'd1, 32'd9, 1'b0, 32'd1, 0, 0);
        run(32'd2, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 0, 0);
        run(32'd6, 32'd9, 1'b1, 32'd0, 0, 0);
        run(32'd3, 32'd10, 1'b1, 32'd0, 0, 0);
        run(32'd0, 32'd11, 1'b1, 32'd0, 0, 0);
        run(32'd5, 32'd5, 1'b1, 32'd0, 0, 0);
        run(32'd3, 32'd11, 1'b0, 32'd4, 4, 0);
        r = ref_inv(32'h1234_5677, 32'hFFFF_FFFB);
        run(32'h1234_5677, 32'hFFFF_FFFB, r[W], r[W-1:0], 0, 1);

        // Reset in the middle of a long computation.
        a_in  = 32'h1234_5677;
        m_in  = 32'hFFFF_FFFB;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("busy_mid_compute", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_inv_out", inv_out, 0);
        check("abort_done", done, 0);
        check("abort_no_inv", no_inv, 0);
        check("abort_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(32'd3, 32'd11, 1'b0, 32'd4, 0, 0);

        for (int i = 0; i < 900; i++) begin
            if (i < 300) rm = $urandom;
            else rm = $urandom_range(255, 3);
            rm[0] = 1'b1;
            if (rm < 3) rm = 32'd3;
            ra  = $urandom % rm;
            sel = $urandom_range(15, 0);
            if (sel == 0) rm[0] = 1'b0;
            else if (sel == 1) ra = rm;
            r = ref_inv(ra, rm);
            run(ra, rm, r[W], r[W-1:0], 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
